// File: rtl/lcd_8080_ctrl.sv
// lcd_8080_ctrl
//   8080-style parallel LCD controller with an Avalon-MM slave front end.
//   Software queues command, data and read-request entries into a FIFO. A
//   small FSM plays each entry out on the panel bus. Setup, strobe and hold
//   times are programmable.
//
// Ports
//   clk_clk, reset_reset_n        system clock, async active-low reset
//   avs_*                         Avalon-MM slave (read latency 1, waitrequest)
//   irq                           level interrupt: enabled, queue empty, FSM idle
//   lcd_cs_n/rd_n/wr_n            panel strobes, active low
//   lcd_data                      bidirectional panel bus, tri-stated unless writing
//   lcd_data_cmd_n                1 = data, 0 = command
//   lcd_mode, lcd_lcdreset_n      static panel pins driven from CTRL
//
// Register map (word address)
//   0 CMD     wr: queue command        rd: read-data view (same as 2)
//   1 DATA    wr: queue data
//   2 RDREQ   wr: queue panel read, dc = wd[0]
//             rd: {valid, rdata}, clears valid
//   3 CTRL    {irq_en, lcdreset_n, mode}
//   4 TIMING  {T_H, T_PW, T_SU}, byte-aligned fields, 0 acts as 1
//   5 STATUS  {level[15:8], busy, full, empty}
//
// FSM states
//   state    | meaning
//   S_IDLE   | bus released, pop next entry when queue not empty
//   S_SETUP  | cs_n low, strobes high, for T_SU cycles
//   S_STROBE | wr_n or rd_n low for T_PW cycles, read sampled on last cycle
//   S_HOLD   | strobes high, cs_n still low, for T_H cycles

module lcd_8080_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic              irq,
  output logic              lcd_cs_n,
  inout  wire  [DATA_W-1:0] lcd_data,
  output logic              lcd_data_cmd_n,
  output logic              lcd_mode,
  output logic              lcd_rd_n,
  output logic              lcd_wr_n,
  output logic              lcd_lcdreset_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;   // {rd, dc, data}

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_nx;

  // configuration
  logic              ctrl_mode, ctrl_rst_n, ctrl_irq_en;
  logic [CNT_W-1:0]  t_su, t_pw, t_h;

  // queue
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              fifo_empty, fifo_full;
  logic              q_sel, push_req, push, pop;
  logic [EW-1:0]     push_entry, pop_entry;

  // current transaction
  logic              cur_rd, cur_dc;
  logic [DATA_W-1:0] cur_data;
  logic [CNT_W-1:0]  lat_pw, lat_h, cnt;
  logic              cnt_tc, sample;
  logic              data_oe;

  // read-back
  logic              rd_valid;
  logic [DATA_W-1:0] rdata;
  logic [31:0]       rd_mux;
  logic              unused_wd;

  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign unused_wd = ^avs_writedata;

  // ---------------------------------------------------------------- decode
  assign q_sel           = (avs_address < 3'd3);
  assign push_req        = avs_write & q_sel;
  // Stall on the registered full flag, so a pop in the same cycle does not
  // open the queue until the next cycle.
  assign avs_waitrequest = push_req & fifo_full;
  assign push            = push_req & ~fifo_full;

  always_comb begin
    push_entry = '0;
    case (avs_address)
      3'd0:    push_entry = {1'b0, 1'b0, avs_writedata[DATA_W-1:0]};
      3'd1:    push_entry = {1'b0, 1'b1, avs_writedata[DATA_W-1:0]};
      3'd2:    push_entry = {1'b1, avs_writedata[0], {DATA_W{1'b0}}};
      default: push_entry = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_mode   <= 1'b0;
      ctrl_rst_n  <= 1'b0;
      ctrl_irq_en <= 1'b0;
      t_su        <= CNT_W'(1);
      t_pw        <= CNT_W'(2);
      t_h         <= CNT_W'(1);
    end else if (avs_write) begin
      if (avs_address == 3'd3) begin
        ctrl_mode   <= avs_writedata[0];
        ctrl_rst_n  <= avs_writedata[1];
        ctrl_irq_en <= avs_writedata[2];
      end
      if (avs_address == 3'd4) begin
        t_su <= avs_writedata[CNT_W-1:0];
        t_pw <= avs_writedata[CNT_W+7:8];
        t_h  <= avs_writedata[CNT_W+15:16];
      end
    end
  end

  // ----------------------------------------------------------------- queue
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign pop        = (state == S_IDLE) & ~fifo_empty;
  assign pop_entry  = fifo_mem[rd_ptr];

  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ------------------------------------------------------------------- FSM
  assign cnt_tc = (cnt == CNT_W'(1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nx = S_SETUP;
      S_SETUP:  if (cnt_tc)      state_nx = S_STROBE;
      S_STROBE: if (cnt_tc)      state_nx = S_HOLD;
      S_HOLD:   if (cnt_tc)      state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    lcd_cs_n = 1'b1;
    lcd_wr_n = 1'b1;
    lcd_rd_n = 1'b1;
    data_oe  = 1'b0;
    case (state)
      S_SETUP: begin
        lcd_cs_n = 1'b0;
        data_oe  = ~cur_rd;
      end
      S_STROBE: begin
        lcd_cs_n = 1'b0;
        lcd_wr_n = cur_rd;
        lcd_rd_n = ~cur_rd;
        data_oe  = ~cur_rd;
      end
      S_HOLD: begin
        lcd_cs_n = 1'b0;
        data_oe  = ~cur_rd;
      end
      default: ;
    endcase
  end

  // Timing is captured at pop so a TIMING write only affects later entries.
  // cnt is a down-counter reloaded with the next phase length at terminal count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cur_rd   <= 1'b0;
      cur_dc   <= 1'b1;
      cur_data <= '0;
      lat_pw   <= CNT_W'(1);
      lat_h    <= CNT_W'(1);
      cnt      <= CNT_W'(1);
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          cur_rd   <= pop_entry[EW-1];
          cur_dc   <= pop_entry[EW-2];
          cur_data <= pop_entry[DATA_W-1:0];
          cnt      <= eff(t_su);
          lat_pw   <= eff(t_pw);
          lat_h    <= eff(t_h);
        end
        S_SETUP:  cnt <= cnt_tc ? lat_pw : cnt - CNT_W'(1);
        S_STROBE: cnt <= cnt_tc ? lat_h  : cnt - CNT_W'(1);
        S_HOLD:   cnt <= cnt_tc ? cnt    : cnt - CNT_W'(1);
        default:  cnt <= CNT_W'(1);
      endcase
    end
  end

  assign lcd_data       = data_oe ? cur_data : {DATA_W{1'bz}};
  assign lcd_data_cmd_n = cur_dc;
  assign lcd_mode       = ctrl_mode;
  assign lcd_lcdreset_n = ctrl_rst_n;
  assign irq            = ctrl_irq_en & fifo_empty & (state == S_IDLE);

  // ------------------------------------------------------------- read path
  assign sample = (state == S_STROBE) & cnt_tc & cur_rd;

  // A completing panel read beats a clearing register read in the same cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_valid <= 1'b0;
      rdata    <= '0;
    end else if (sample) begin
      rd_valid <= 1'b1;
      rdata    <= lcd_data;
    end else if (avs_read && (avs_address == 3'd0 || avs_address == 3'd2)) begin
      rd_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0, 3'd2: rd_mux = {rd_valid, {(31-DATA_W){1'b0}}, rdata};
      3'd3:       rd_mux = {29'd0, ctrl_irq_en, ctrl_rst_n, ctrl_mode};
      3'd4:       rd_mux = 32'(t_su) | (32'(t_pw) << 8) | (32'(t_h) << 16);
      3'd5:       rd_mux = (32'(level) << 8) |
                           {29'd0, (state != S_IDLE), fifo_full, fifo_empty};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= rd_mux;
  end

endmodule
